// File: rtl/toy_lsu_req_arb_pkg.sv
// Shared types for the LSU request arbiter: AGU request payload and arbitration mode.
package toy_lsu_req_arb_pkg;

  typedef enum logic [0:0] {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [5:0]  tag;
  } agu_pkg_t;

endpackage

// File: rtl/toy_lsu_req_fifo2.sv
// Two-entry request buffer holding {payload, source id}; head is stable until popped.
module toy_lsu_req_fifo2
  import toy_lsu_req_arb_pkg::*;
#(
  parameter int unsigned SrcW = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  agu_pkg_t        pld_i,
  input  logic [SrcW-1:0] src_i,
  input  logic            pop_i,
  output logic [1:0]      cnt_o,
  output logic            can_acc_o,
  output agu_pkg_t        pld_o,
  output logic [SrcW-1:0] src_o
);

  logic [1:0]      cnt_q, cnt_d;
  logic            wr_ptr_q, rd_ptr_q;
  logic            push_en, pop_en;
  agu_pkg_t        pld_q [2];
  logic [SrcW-1:0] src_q [2];

  assign can_acc_o = (cnt_q != 2'd2);
  assign push_en   = push_i & can_acc_o;
  assign pop_en    = pop_i & (cnt_q != 2'd0);

  always_comb begin
    cnt_d = cnt_q;
    case ({push_en, pop_en})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q    <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      src_q[0] <= '0;
      src_q[1] <= '0;
    end else begin
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_q ^ push_en;
      rd_ptr_q <= rd_ptr_q ^ pop_en;
      if (push_en) src_q[wr_ptr_q] <= src_i;
    end
  end

  // Payload storage is deliberately left out of reset; it is only observed while cnt != 0.
  always_ff @(posedge clk_i) begin
    if (push_en) pld_q[wr_ptr_q] <= pld_i;
  end

  assign cnt_o = cnt_q;
  assign pld_o = pld_q[rd_ptr_q];
  assign src_o = src_q[rd_ptr_q];

endmodule

// File: rtl/toy_lsu_req_arb.sv
// N-channel LSU request arbiter: fixed priority with starvation aging, or round robin,
// feeding a 2-entry registered buffer so m_rdy_i never reaches v_s_rdy_o combinationally.
module toy_lsu_req_arb
  import toy_lsu_req_arb_pkg::*;
#(
  parameter int unsigned NUM_CH       = 3,
  parameter arb_mode_e   ARB_MODE     = ARB_FIXED,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned SRC_W        = $clog2(NUM_CH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NUM_CH-1:0] v_s_vld_i,
  output logic [NUM_CH-1:0] v_s_rdy_o,
  input  agu_pkg_t          v_s_pld_i [NUM_CH],
  output logic              m_vld_o,
  input  logic              m_rdy_i,
  output agu_pkg_t          m_pld_o,
  output logic [SRC_W-1:0]  m_src_o
);

  localparam int unsigned CntW = (STARVE_LIMIT == 0) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

  logic [NUM_CH-1:0] urgent, pref, grant, acc;
  logic [SRC_W-1:0]  grant_idx, rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]   starve_q [NUM_CH];
  logic [CntW-1:0]   starve_d [NUM_CH];
  logic              grant_found, can_acc, push;
  logic [1:0]        fifo_cnt;
  agu_pkg_t          push_pld;

  always_comb begin
    urgent = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      urgent[i] = (STARVE_LIMIT != 0) && (starve_q[i] == Limit);
    end
  end

  // First pass searches the preferred set (urgent, or at/after rr_ptr); second pass wraps.
  always_comb begin
    pref        = '0;
    grant       = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (ARB_MODE == ARB_RR) pref[i] = v_s_vld_i[i] && (i >= 32'(rr_ptr_q));
      else                    pref[i] = v_s_vld_i[i] && urgent[i];
    end
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!grant_found && pref[i]) begin
        grant_found = 1'b1;
        grant[i]    = 1'b1;
        grant_idx   = SRC_W'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!grant_found && v_s_vld_i[i]) begin
        grant_found = 1'b1;
        grant[i]    = 1'b1;
        grant_idx   = SRC_W'(i);
      end
    end
  end

  assign acc       = grant & {NUM_CH{can_acc & rst_ni}};
  assign push      = |acc;
  assign v_s_rdy_o = acc;

  always_comb begin
    push_pld = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (grant[i]) push_pld = v_s_pld_i[i];
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (ARB_MODE == ARB_RR && push) begin
      rr_ptr_d = (grant_idx == SRC_W'(NUM_CH - 1)) ? '0 : grant_idx + SRC_W'(1);
    end
  end

  // Aging only counts cycles where another channel actually won the buffer slot.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      starve_d[i] = starve_q[i];
      if (ARB_MODE == ARB_RR || !v_s_vld_i[i] || acc[i]) begin
        starve_d[i] = '0;
      end else if (push && starve_q[i] != Limit) begin
        starve_d[i] = starve_q[i] + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) starve_q[i] <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      for (int unsigned i = 0; i < NUM_CH; i++) starve_q[i] <= starve_d[i];
    end
  end

  toy_lsu_req_fifo2 #(
    .SrcW(SRC_W)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .push_i   (push),
    .pld_i    (push_pld),
    .src_i    (grant_idx),
    .pop_i    (m_rdy_i),
    .cnt_o    (fifo_cnt),
    .can_acc_o(can_acc),
    .pld_o    (m_pld_o),
    .src_o    (m_src_o)
  );

  assign m_vld_o = (fifo_cnt != 2'd0);

endmodule

// File: tb/tb_toy_lsu_req_arb.sv
// Bench for toy_lsu_req_arb: three instances (fixed, aging, round robin) driven from
// vector tables and short hand sequences, with an in-order scoreboard on the output port.
module tb_toy_lsu_req_arb;
  import toy_lsu_req_arb_pkg::*;

  localparam int NI      = 3;
  localparam int MaxCh   = 4;
  localparam int SbDepth = 64;

  typedef struct packed {
    agu_pkg_t   pld;
    logic [1:0] src;
  } sb_t;

  typedef struct packed {
    logic [1:0] inst;
    logic [3:0] vld;
    logic       mrdy;
    logic [3:0] rdy;
    logic       mvld;
    logic [1:0] src;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [MaxCh-1:0] vld  [NI];
  logic [MaxCh-1:0] rdy  [NI];
  logic             mrdy [NI];
  logic             rstn [NI];
  logic             mvld [NI];
  agu_pkg_t         mpld [NI];
  logic [1:0]       msrc [NI];
  agu_pkg_t         pld  [NI][MaxCh];
  int unsigned      seq  [NI][MaxCh];

  sb_t sb     [NI][SbDepth];
  int  wr_i   [NI];
  int  rd_i   [NI];
  logic hold_q [NI];
  sb_t  hold_v [NI];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned Nc  = (g == 2) ? 4 : 3;
    localparam int unsigned Lim = (g == 1) ? 4 : 0;
    localparam arb_mode_e  Mode = (g == 2) ? ARB_RR : ARB_FIXED;
    agu_pkg_t      pld_l [Nc];
    logic [Nc-1:0] rdy_l;
    for (genvar c = 0; c < Nc; c++) begin : g_pld
      assign pld_l[c] = pld[g][c];
    end
    toy_lsu_req_arb #(
      .NUM_CH      (Nc),
      .ARB_MODE    (Mode),
      .STARVE_LIMIT(Lim)
    ) u_dut (
      .clk_i    (clk),
      .rst_ni   (rstn[g]),
      .v_s_vld_i(vld[g][Nc-1:0]),
      .v_s_rdy_o(rdy_l),
      .v_s_pld_i(pld_l),
      .m_vld_o  (mvld[g]),
      .m_rdy_i  (mrdy[g]),
      .m_pld_o  (mpld[g]),
      .m_src_o  (msrc[g])
    );
    assign rdy[g] = MaxCh'(rdy_l);
  end

  function automatic void chk(input string name, input int g, input logic [63:0] act,
                              input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d got %0h want %0h", name, g, act, exp);
    end
  endfunction

  function automatic agu_pkg_t mk(input int g, input int c, input int unsigned s);
    agu_pkg_t p;
    p.addr = {8'(g), 8'(c), 16'(s)};
    p.we   = s[0];
    p.be   = 4'(c + 1);
    p.tag  = 6'(s);
    return p;
  endfunction

  function automatic vec_t v(input int inst, input logic [3:0] vl, input logic mr,
                             input logic [3:0] rd, input logic mv, input int src);
    vec_t r;
    r.inst = 2'(inst);
    r.vld  = vl;
    r.mrdy = mr;
    r.rdy  = rd;
    r.mvld = mv;
    r.src  = 2'(src);
    return r;
  endfunction

  // Scoreboard: accepted requests are pushed, output pops are compared in order.
  task automatic mon();
    logic [MaxCh-1:0] a;
    for (int g = 0; g < NI; g++) begin
      if (!rstn[g]) begin
        wr_i[g]   = 0;
        rd_i[g]   = 0;
        hold_q[g] = 1'b0;
      end else begin
        a = vld[g] & rdy[g];
        chk("rdy_without_vld", g, rdy[g] & ~vld[g], 0);
        chk("rdy_onehot0", g, 64'($onehot0(rdy[g])), 1);
        if (hold_q[g]) begin
          chk("head_hold_vld", g, mvld[g], 1);
          chk("head_hold", g, {mpld[g], msrc[g]}, hold_v[g]);
        end
        if (mvld[g] && mrdy[g]) begin
          chk("sb_nonempty_on_pop", g, 64'(wr_i[g] != rd_i[g]), 1);
          if (wr_i[g] != rd_i[g]) begin
            chk("pop_entry", g, {mpld[g], msrc[g]}, sb[g][rd_i[g] % SbDepth]);
            rd_i[g]++;
          end
        end
        for (int c = 0; c < MaxCh; c++) begin
          if (a[c]) begin
            sb[g][wr_i[g] % SbDepth] = {pld[g][c], 2'(c)};
            wr_i[g]++;
            seq[g][c]++;
          end
        end
        chk("occupancy_le_2", g, 64'((wr_i[g] - rd_i[g]) <= 2), 1);
        hold_q[g] = mvld[g] & !mrdy[g];
        hold_v[g] = {mpld[g], msrc[g]};
      end
    end
  endtask

  task automatic to_neg();
    for (int g = 0; g < NI; g++)
      for (int c = 0; c < MaxCh; c++) pld[g][c] = mk(g, c, seq[g][c]);
    @(negedge clk);
  endtask

  task automatic finish_cyc();
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int g = 0; g < NI; g++) begin
      vld[g]  = '0;
      mrdy[g] = 1'b1;
      rstn[g] = 1'b1;
    end
  endtask

  vec_t tbl [$];

  initial begin
    int gi;
    for (int g = 0; g < NI; g++) begin
      wr_i[g] = 0; rd_i[g] = 0; hold_q[g] = 1'b0; hold_v[g] = '0;
      for (int c = 0; c < MaxCh; c++) seq[g][c] = 0;
      vld[g] = '1; mrdy[g] = 1'b1; rstn[g] = 1'b0;
    end
    @(posedge clk);
    #1;

    // Reset held with every request valid: nothing accepted, nothing presented.
    for (int k = 0; k < 3; k++) begin
      to_neg();
      for (int g = 0; g < NI; g++) begin
        chk("reset_rdy", g, rdy[g], 0);
        chk("reset_mvld", g, mvld[g], 0);
      end
      finish_cyc();
    end

    // Fixed priority, no aging.
    tbl.push_back(v(0, 4'b0111, 1, 4'b0001, 0, 0));
    tbl.push_back(v(0, 4'b0111, 1, 4'b0001, 1, 0));
    tbl.push_back(v(0, 4'b0111, 1, 4'b0001, 1, 0));
    tbl.push_back(v(0, 4'b0110, 1, 4'b0010, 1, 0));
    tbl.push_back(v(0, 4'b0100, 1, 4'b0100, 1, 1));
    tbl.push_back(v(0, 4'b0000, 1, 4'b0000, 1, 2));
    tbl.push_back(v(0, 4'b0000, 1, 4'b0000, 0, 0));
    tbl.push_back(v(0, 4'b0111, 0, 4'b0001, 0, 0));
    tbl.push_back(v(0, 4'b0111, 0, 4'b0001, 1, 0));
    tbl.push_back(v(0, 4'b0111, 0, 4'b0000, 1, 0));
    tbl.push_back(v(0, 4'b0111, 1, 4'b0000, 1, 0));
    tbl.push_back(v(0, 4'b0111, 1, 4'b0001, 1, 0));
    tbl.push_back(v(0, 4'b0000, 1, 4'b0000, 1, 0));
    // Aging with limit 4: ch0 wins four times, then ch1 once.
    tbl.push_back(v(1, 4'b0011, 1, 4'b0001, 0, 0));
    for (int k = 0; k < 3; k++) tbl.push_back(v(1, 4'b0011, 1, 4'b0001, 1, 0));
    tbl.push_back(v(1, 4'b0011, 1, 4'b0010, 1, 0));
    tbl.push_back(v(1, 4'b0011, 1, 4'b0001, 1, 1));
    for (int k = 0; k < 3; k++) tbl.push_back(v(1, 4'b0011, 1, 4'b0001, 1, 0));
    tbl.push_back(v(1, 4'b0011, 1, 4'b0010, 1, 0));
    tbl.push_back(v(1, 4'b0011, 1, 4'b0001, 1, 1));
    tbl.push_back(v(1, 4'b0000, 1, 4'b0000, 1, 0));
    // Round robin over four channels, then ch0/ch2 only from rr_ptr=3.
    tbl.push_back(v(2, 4'b1111, 1, 4'b0001, 0, 0));
    tbl.push_back(v(2, 4'b1111, 1, 4'b0010, 1, 0));
    tbl.push_back(v(2, 4'b1111, 1, 4'b0100, 1, 1));
    tbl.push_back(v(2, 4'b1111, 1, 4'b1000, 1, 2));
    tbl.push_back(v(2, 4'b1111, 1, 4'b0001, 1, 3));
    tbl.push_back(v(2, 4'b1111, 1, 4'b0010, 1, 0));
    tbl.push_back(v(2, 4'b0100, 1, 4'b0100, 1, 1));
    tbl.push_back(v(2, 4'b0101, 1, 4'b0001, 1, 2));
    tbl.push_back(v(2, 4'b0101, 1, 4'b0100, 1, 0));
    tbl.push_back(v(2, 4'b0101, 1, 4'b0001, 1, 2));
    tbl.push_back(v(2, 4'b0101, 1, 4'b0100, 1, 0));
    tbl.push_back(v(2, 4'b0000, 1, 4'b0000, 1, 2));
    // Backpressure: two accepts fill the buffer, head holds, then drains in order.
    tbl.push_back(v(2, 4'b1111, 0, 4'b1000, 0, 0));
    tbl.push_back(v(2, 4'b1111, 0, 4'b0001, 1, 3));
    for (int k = 0; k < 3; k++) tbl.push_back(v(2, 4'b1111, 0, 4'b0000, 1, 3));
    tbl.push_back(v(2, 4'b1111, 1, 4'b0000, 1, 3));
    tbl.push_back(v(2, 4'b1111, 1, 4'b0010, 1, 0));
    tbl.push_back(v(2, 4'b1111, 1, 4'b0100, 1, 1));
    tbl.push_back(v(2, 4'b1111, 1, 4'b1000, 1, 2));
    tbl.push_back(v(2, 4'b0000, 1, 4'b0000, 1, 3));
    tbl.push_back(v(2, 4'b0000, 1, 4'b0000, 0, 0));

    foreach (tbl[n]) begin
      idle_all();
      gi       = int'(tbl[n].inst);
      vld[gi]  = tbl[n].vld;
      mrdy[gi] = tbl[n].mrdy;
      to_neg();
      chk($sformatf("row%0d_rdy", n), gi, rdy[gi], tbl[n].rdy);
      chk($sformatf("row%0d_mvld", n), gi, mvld[gi], tbl[n].mvld);
      if (tbl[n].mvld) chk($sformatf("row%0d_msrc", n), gi, msrc[gi], tbl[n].src);
      finish_cyc();
    end

    // Reset with a full buffer and rr_ptr=3: entries discarded, pointer back to 0.
    idle_all();
    vld[2] = 4'b0010; mrdy[2] = 1'b0;
    to_neg();
    chk("mid_rst_pre1_rdy", 2, rdy[2], 4'b0010);
    finish_cyc();
    vld[2] = 4'b1111;
    to_neg();
    chk("mid_rst_pre2_rdy", 2, rdy[2], 4'b0100);
    finish_cyc();
    rstn[2] = 1'b0;
    to_neg();
    chk("mid_rst_rdy", 2, rdy[2], 0);
    finish_cyc();
    rstn[2] = 1'b1; mrdy[2] = 1'b1;
    to_neg();
    chk("post_rst_mvld", 2, mvld[2], 0);
    chk("post_rst_rr_ptr", 2, rdy[2], 4'b0001);
    finish_cyc();
    vld[2] = 4'b0000;
    to_neg();
    chk("post_rst_first_mvld", 2, mvld[2], 1);
    chk("post_rst_first_msrc", 2, msrc[2], 0);
    finish_cyc();

    idle_all();
    for (int k = 0; k < 3; k++) begin
      to_neg();
      finish_cyc();
    end
    for (int g = 0; g < NI; g++) begin
      chk("sb_drained", g, 64'(wr_i[g] - rd_i[g]), 0);
      chk("final_mvld", g, mvld[g], 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
